// File: rtl/rt_mem_pkg.sv
// Shared memory-path definitions for tri_reader and result_writer:
// halfword geometry, the writer state encoding and the Avalon byteenable.
package rt_mem_pkg;

   localparam int HWORD_W         = 16;
   localparam int BYTES_PER_HWORD = 2;

   localparam logic [BYTES_PER_HWORD-1:0] AVM_BYTEENABLE = 2'b11;

   typedef enum logic {
      IDLE  = 1'b0,
      WRITE = 1'b1
   } wr_state_e;

endpackage

// File: rtl/result_writer_hword_serializer.sv
// Halfword serializer: walks one block MSB-halfword first onto the Avalon
// write port, holding address/data/write stable while waitrequest is high.
module hword_serializer
   import rt_mem_pkg::*;
#(
   parameter int NDWORDS = 1
)
(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    load_i,
   input  logic [31:0]             addr_i,
   input  logic [32*NDWORDS-1:0]   data_i,
   input  logic                    waitrequest_i,
   output logic                    write_o,
   output logic [31:0]             address_o,
   output logic [HWORD_W-1:0]      writedata_o,
   output logic                    busy_o,
   output logic                    lastXfer_o,
   output logic                    done_o
);

   localparam int BLOCKSZ = 32*NDWORDS;
   localparam int NHW     = 2*NDWORDS;
   localparam int CNT_W   = $clog2(NHW) + 1;

   wr_state_e            state_q;
   logic                 write_q;
   logic                 done_q;
   logic [31:0]          addr_q;
   logic [HWORD_W-1:0]   wdata_q;
   logic [BLOCKSZ-1:0]   shift_q;
   logic [CNT_W-1:0]     remain_q;
   logic                 xfer;
   logic                 lastXfer;

   assign xfer     = write_q && !waitrequest_i;
   assign lastXfer = xfer && (remain_q == '0);

   // remain_q counts halfwords still to go after the one currently presented;
   // a load on the last transfer keeps write high with no bubble.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         write_q  <= 1'b0;
         done_q   <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         shift_q  <= '0;
         remain_q <= '0;
      end else begin
         done_q <= lastXfer;
         if (load_i) begin
            state_q  <= WRITE;
            write_q  <= 1'b1;
            addr_q   <= addr_i;
            wdata_q  <= data_i[BLOCKSZ-1 -: HWORD_W];
            shift_q  <= data_i << HWORD_W;
            remain_q <= CNT_W'(NHW - 1);
         end else if (lastXfer) begin
            state_q <= IDLE;
            write_q <= 1'b0;
         end else if (xfer) begin
            addr_q   <= addr_q + 32'(BYTES_PER_HWORD);
            wdata_q  <= shift_q[BLOCKSZ-1 -: HWORD_W];
            shift_q  <= shift_q << HWORD_W;
            remain_q <= remain_q - CNT_W'(1);
         end
      end
   end

   assign write_o     = write_q;
   assign address_o   = addr_q;
   assign writedata_o = wdata_q;
   assign busy_o      = (state_q == WRITE);
   assign lastXfer_o  = lastXfer;
   assign done_o      = done_q;

endmodule

// File: rtl/result_writer.sv
// Block writer: turns (baseaddr, index, data) requests into halfword Avalon
// writes. Define RESULT_WRITER_BUF_EN to add a one-entry request buffer.
module result_writer
   import rt_mem_pkg::*;
#(
   parameter int NDWORDS = 1
)
(
   input  logic                    clk,
   input  logic                    reset,
   input  logic [31:0]             baseaddr,
   input  logic [31:0]             index,
   input  logic                    write,
   input  logic [32*NDWORDS-1:0]   data,
   output logic                    iready,
   output logic                    wrdone,
   output logic                    avm_m0_write,
   output logic [31:0]             avm_m0_address,
   output logic [HWORD_W-1:0]      avm_m0_writedata,
   output logic [BYTES_PER_HWORD-1:0] avm_m0_byteenable,
   input  logic                    avm_m0_waitrequest
);

   localparam int BLOCKSZ = 32*NDWORDS;

   logic               busy;
   logic               lastXfer;
   logic               loadSlot;
   logic               accept;
   logic               serLoad;
   logic [31:0]        reqAddr;
   logic [31:0]        loadAddr;
   logic [BLOCKSZ-1:0] loadData;

   assign reqAddr  = baseaddr + index * 32'(4*NDWORDS);
   assign loadSlot = !busy || lastXfer;

`ifdef RESULT_WRITER_BUF_EN
   logic               bufValid_q;
   logic               bufValid_d;
   logic [31:0]        bufAddr_q;
   logic [BLOCKSZ-1:0] bufData_q;
   logic               bufCapture;

   // A request arriving on the last transfer with the buffer empty bypasses
   // the buffer and loads directly, so the buffer is always empty in IDLE.
   assign iready     = !busy || !bufValid_q;
   assign accept     = write && iready;
   assign bufCapture = accept && busy && !lastXfer;
   assign serLoad    = loadSlot && (bufValid_q || accept);
   assign loadAddr   = bufValid_q ? bufAddr_q : reqAddr;
   assign loadData   = bufValid_q ? bufData_q : data;

   always_comb begin
      bufValid_d = bufValid_q;
      if (lastXfer && bufValid_q) begin
         bufValid_d = 1'b0;
      end else if (bufCapture) begin
         bufValid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bufValid_q <= 1'b0;
         bufAddr_q  <= '0;
         bufData_q  <= '0;
      end else begin
         bufValid_q <= bufValid_d;
         if (bufCapture) begin
            bufAddr_q <= reqAddr;
            bufData_q <= data;
         end
      end
   end
`else
   assign iready   = !busy;
   assign accept   = write && iready;
   assign serLoad  = accept && loadSlot;
   assign loadAddr = reqAddr;
   assign loadData = data;
`endif

   hword_serializer #(.NDWORDS(NDWORDS)) u_ser (
      .clk           (clk),
      .reset         (reset),
      .load_i        (serLoad),
      .addr_i        (loadAddr),
      .data_i        (loadData),
      .waitrequest_i (avm_m0_waitrequest),
      .write_o       (avm_m0_write),
      .address_o     (avm_m0_address),
      .writedata_o   (avm_m0_writedata),
      .busy_o        (busy),
      .lastXfer_o    (lastXfer),
      .done_o        (wrdone)
   );

   assign avm_m0_byteenable = AVM_BYTEENABLE;

endmodule

// File: tb/tb_result_writer.sv
// Self-checking bench for result_writer: a halfword-queue reference model checks
// every cycle, plus table vectors and hand sequences for stalls, overlap and reset.
module tb_result_writer;
   import rt_mem_pkg::*;

   localparam int NDWORDS = 1;
   localparam int NHW     = 2*NDWORDS;
   localparam int BLOCKSZ = 32*NDWORDS;

   logic               clk = 1'b0;
   logic               reset;
   logic [31:0]        baseaddr;
   logic [31:0]        index;
   logic               write;
   logic [BLOCKSZ-1:0] data;
   logic               iready;
   logic               wrdone;
   logic               avm_m0_write;
   logic [31:0]        avm_m0_address;
   logic [15:0]        avm_m0_writedata;
   logic [1:0]         avm_m0_byteenable;
   logic               avm_m0_waitrequest;

   always #5 clk = ~clk;

   result_writer #(.NDWORDS(NDWORDS)) dut (
      .clk                (clk),
      .reset              (reset),
      .baseaddr           (baseaddr),
      .index              (index),
      .write              (write),
      .data               (data),
      .iready             (iready),
      .wrdone             (wrdone),
      .avm_m0_write       (avm_m0_write),
      .avm_m0_address     (avm_m0_address),
      .avm_m0_writedata   (avm_m0_writedata),
      .avm_m0_byteenable  (avm_m0_byteenable),
      .avm_m0_waitrequest (avm_m0_waitrequest)
   );

   typedef struct {
      logic [31:0] addr;
      logic [15:0] data;
      bit          last;
   } hword_t;

   typedef struct {
      logic [31:0]        base;
      logic [31:0]        idx;
      logic [BLOCKSZ-1:0] dat;
      logic [31:0]        a0;
      logic [31:0]        a1;
      logic [15:0]        d0;
      logic [15:0]        d1;
   } vec_t;

   hword_t      expQ[$];
   bit          expDone;
   int          total = 0;
   int          bad = 0;
   int          cycleNo = 0;
   logic [31:0] obsAddr[$];
   logic [15:0] obsData[$];
   int          obsCycle[$];
   int          doneCount;
   int          doneCycle;
   logic [31:0] acceptIdx[$];
   vec_t        vecs[5];

   task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   function automatic bit expReady();
`ifdef RESULT_WRITER_BUF_EN
      return expQ.size() <= NHW;
`else
      return expQ.size() == 0;
`endif
   endfunction

   // Reference: each accepted block becomes NHW halfwords at consecutive even addresses.
   function automatic void pushBlock(logic [31:0] b, logic [31:0] i, logic [BLOCKSZ-1:0] d);
      hword_t h;
      for (int k = 0; k < NHW; k++) begin
         h.addr = b + i * (4*NDWORDS) + 32'(2*k);
         h.data = 16'(d >> (BLOCKSZ - 16*(k+1)));
         h.last = (k == NHW-1);
         expQ.push_back(h);
      end
   endfunction

   function automatic void clearObs();
      obsAddr.delete();
      obsData.delete();
      obsCycle.delete();
      acceptIdx.delete();
      doneCount = 0;
      doneCycle = -1;
   endfunction

   // Compares outputs against the model, then advances the model over the coming edge.
   task automatic checkOutput();
      bit xfer;
      bit acc;
      if (reset) begin
         expQ.delete();
         expDone = 1'b0;
         return;
      end
      check("iready", iready, expReady());
      check("avm_write", avm_m0_write, expQ.size() > 0);
      check("byteenable", avm_m0_byteenable, 2'b11);
      check("wrdone", wrdone, expDone);
      if (wrdone) begin
         doneCount++;
         doneCycle = cycleNo;
      end
      if (expQ.size() > 0) begin
         check("avm_address", avm_m0_address, expQ[0].addr);
         check("avm_writedata", avm_m0_writedata, expQ[0].data);
      end
      xfer = avm_m0_write && !avm_m0_waitrequest;
      acc  = write && iready;
      expDone = 1'b0;
      if (xfer) begin
         obsAddr.push_back(avm_m0_address);
         obsData.push_back(avm_m0_writedata);
         obsCycle.push_back(cycleNo);
         if (expQ.size() > 0) begin
            expDone = expQ[0].last;
            void'(expQ.pop_front());
         end
      end
      if (acc) begin
         acceptIdx.push_back(index);
         pushBlock(baseaddr, index, data);
      end
   endtask

   task automatic applyStimulus(input bit w, input logic [31:0] b, input logic [31:0] i,
                                input logic [BLOCKSZ-1:0] d, input bit wr, input bit rs);
      write              = w;
      baseaddr           = b;
      index              = i;
      data               = d;
      avm_m0_waitrequest = wr;
      reset              = rs;
      checkOutput();
      @(posedge clk);
      @(negedge clk);
      cycleNo++;
   endtask

   task automatic idle(input bit wr);
      applyStimulus(1'b0, baseaddr, index, data, wr, 1'b0);
   endtask

   task automatic waitDone(input int want, input int budget);
      for (int c = 0; c < budget && doneCount < want; c++) idle(1'b0);
      check("wrdone_count", doneCount, want);
   endtask

   task automatic runVector(input vec_t v, input string tag);
      clearObs();
      applyStimulus(1'b1, v.base, v.idx, v.dat, 1'b0, 1'b0);
      waitDone(1, 20);
      idle(1'b0);
      idle(1'b0);
      check({tag, "_ndone"}, doneCount, 1);
      check({tag, "_nxfer"}, obsAddr.size(), 2);
      if (obsAddr.size() >= 2) begin
         check({tag, "_a0"}, obsAddr[0], v.a0);
         check({tag, "_d0"}, obsData[0], v.d0);
         check({tag, "_a1"}, obsAddr[1], v.a1);
         check({tag, "_d1"}, obsData[1], v.d1);
         check({tag, "_b2b"}, obsCycle[1], obsCycle[0] + 1);
         check({tag, "_donelat"}, doneCycle, obsCycle[1] + 1);
      end
   endtask

   initial begin
      write = 1'b0; baseaddr = '0; index = '0; data = '0;
      avm_m0_waitrequest = 1'b0; reset = 1'b1;
      expDone = 1'b0;
      clearObs();
      @(negedge clk);
      applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b1);
      applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0);
      check("rst_write", avm_m0_write, 1'b0);
      check("rst_address", avm_m0_address, 32'h0);
      check("rst_writedata", avm_m0_writedata, 16'h0);
      check("rst_wrdone", wrdone, 1'b0);
      check("rst_iready", iready, 1'b1);

      vecs[0] = '{32'h0000_0000, 32'd0, 32'h000A_000B, 32'h0000_0000, 32'h0000_0002, 16'h000A, 16'h000B};
      vecs[1] = '{32'h0000_1000, 32'd3, 32'h0102_0304, 32'h0000_100C, 32'h0000_100E, 16'h0102, 16'h0304};
      vecs[2] = '{32'hFFFF_FFFC, 32'd1, 32'hDEAD_BEEF, 32'h0000_0000, 32'h0000_0002, 16'hDEAD, 16'hBEEF};
      vecs[3] = '{32'h2000_0000, 32'h10, 32'hCAFE_F00D, 32'h2000_0040, 32'h2000_0042, 16'hCAFE, 16'hF00D};
      vecs[4] = '{32'h0000_0100, 32'h4000_0001, 32'h8001_7FFE, 32'h0000_0104, 32'h0000_0106, 16'h8001, 16'h7FFE};
      for (int v = 0; v < 5; v++) runVector(vecs[v], $sformatf("vec%0d", v));

      // Stall the first halfword for three cycles.
      clearObs();
      applyStimulus(1'b1, 32'h0000_0200, 32'd2, 32'h1234_5678, 1'b0, 1'b0);
      for (int c = 0; c < 3; c++) begin
         check("stall_write", avm_m0_write, 1'b1);
         check("stall_addr", avm_m0_address, 32'h0000_0208);
         check("stall_data", avm_m0_writedata, 16'h1234);
         idle(1'b1);
      end
      waitDone(1, 20);
      idle(1'b0);
      check("stall_nxfer", obsAddr.size(), 2);
      check("stall_ndone", doneCount, 1);

      // Back-to-back requests idx 1,2,3.
      clearObs();
      applyStimulus(1'b1, 32'h0, 32'd1, 32'h1111_2222, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h0, 32'd2, 32'h3333_4444, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h0, 32'd3, 32'h5555_6666, 1'b0, 1'b0);
`ifdef RESULT_WRITER_BUF_EN
      waitDone(2, 30);
      check("ovl_naccept", acceptIdx.size(), 2);
      check("ovl_nxfer", obsAddr.size(), 4);
      if (acceptIdx.size() >= 2) check("ovl_acc1", acceptIdx[1], 32'd2);
      if (obsCycle.size() >= 4) check("ovl_b2b", obsCycle[3] - obsCycle[0], 3);
`else
      waitDone(1, 30);
      check("ovl_naccept", acceptIdx.size(), 1);
      check("ovl_nxfer", obsAddr.size(), 2);
`endif
      if (acceptIdx.size() >= 1) check("ovl_acc0", acceptIdx[0], 32'd1);
      idle(1'b0);

      // Reset after the first halfword, with waitrequest high at the reset edge.
      clearObs();
      applyStimulus(1'b1, 32'h0000_0040, 32'd2, 32'hAAAA_5555, 1'b0, 1'b0);
      idle(1'b0);
      applyStimulus(1'b0, 32'h0000_0040, 32'd2, 32'hAAAA_5555, 1'b1, 1'b1);
      applyStimulus(1'b0, 32'h0000_0040, 32'd2, 32'hAAAA_5555, 1'b1, 1'b0);
      check("abort_write", avm_m0_write, 1'b0);
      check("abort_iready", iready, 1'b1);
      check("abort_address", avm_m0_address, 32'h0);
      check("abort_writedata", avm_m0_writedata, 16'h0);
      for (int c = 0; c < 4; c++) idle(1'b0);
      check("abort_ndone", doneCount, 0);
      check("abort_nxfer", obsAddr.size(), 1);
      runVector('{32'h0000_0040, 32'd2, 32'h9876_5432, 32'h0000_0048, 32'h0000_004A, 16'h9876, 16'h5432}, "fresh");

      // Randomized traffic against the reference model.
      for (int c = 0; c < 400; c++) begin
         applyStimulus($urandom_range(0, 2) == 0, $urandom(), $urandom_range(0, 1000),
                       BLOCKSZ'($urandom()), $urandom_range(0, 3) == 0,
                       $urandom_range(0, 99) == 0);
      end
      for (int c = 0; c < 40 && expQ.size() > 0; c++) idle(1'b0);
      check("drain_empty", expQ.size(), 0);
      idle(1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/result_writer.md
RESULT_WRITER -- requirements
Module: result_writer

Interface
REQ-001 SHALL have parameter NDWORDS, default 1, 32-bit words per block; BLOCKSZ = 32*NDWORDS, NHW = 2*NDWORDS halfwords.
REQ-002 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port baseaddr, input, 32, byte base address of the block array.
REQ-005 SHALL have port index, input, 32, block index, sampled at acceptance.
REQ-006 SHALL have port write, input, 1, request strobe; accepted when write && iready.
REQ-007 SHALL have port data, input, BLOCKSZ, block payload, sampled at acceptance.
REQ-008 SHALL have port iready, output, 1, writer can accept a request this cycle.
REQ-009 SHALL have port wrdone, output, 1, one-cycle pulse per completed block.
REQ-010 SHALL have ports avm_m0_write (out,1), avm_m0_address (out,32), avm_m0_writedata (out,16), avm_m0_byteenable (out,2), avm_m0_waitrequest (in,1), as an Avalon-MM write-only master.

Function
REQ-011 SHALL compute block address A = baseaddr + index*(4*NDWORDS) with 32-bit wrap-around, no overflow flag.
REQ-012 SHALL emit halfword k (k = 0..NHW-1) at address A + 2k, carrying data[BLOCKSZ-1-16k -: 16], MSB halfword first, matching tri_reader assembly order.
REQ-013 SHALL use states IDLE and WRITE; IDLE->WRITE on acceptance; WRITE->IDLE when the last halfword transfers and no buffered request exists.
REQ-014 SHALL assert avm_m0_write the cycle after acceptance (latency 1).
REQ-015 SHALL treat a halfword as transferred when avm_m0_write && !avm_m0_waitrequest; SHALL hold address, writedata and write stable while waitrequest is high.
REQ-016 SHALL issue halfwords back-to-back, no bubbles when waitrequest is low.
REQ-017 SHALL pulse wrdone for exactly one cycle, the cycle after the last halfword transfers.
REQ-018 SHALL drive avm_m0_byteenable constant 2'b11.
REQ-019 SHALL ignore write while iready is low; no request is lost or duplicated.
REQ-020 SHALL drive iready high in IDLE; without buffering, iready is low throughout WRITE.

Reset
REQ-021 SHALL, on reset, enter IDLE, abort any in-flight block without completing it, and clear the buffer.
REQ-022 SHALL hold reset values: avm_m0_write 0, avm_m0_address 0, avm_m0_writedata 0, wrdone 0, iready 1 once state is IDLE.
REQ-023 SHALL deassert avm_m0_write on the edge at which reset is sampled, even if waitrequest is high.

Configuration
REQ-024 SHALL support macro RESULT_WRITER_BUF_EN: when defined, a one-entry request buffer is compiled in.
REQ-025 SHALL, with RESULT_WRITER_BUF_EN, hold iready high in WRITE while the buffer is empty; a buffered block starts on the cycle after the current last transfer, keeping avm_m0_write continuously high.
REQ-026 SHALL, without RESULT_WRITER_BUF_EN, have no buffer storage; iready follows REQ-020.

Structure
REQ-027 SHALL place HWORD_W = 16, BYTES_PER_HWORD = 2, the writer state enum and the Avalon byteenable constant in shared package rt_mem_pkg, imported by tri_reader and result_writer.
REQ-028 SHALL be a single module with one natural sub-module hword_serializer, comprising the halfword counter, shift register and Avalon drive.

Verification
REQ-029 SHALL cover: NDWORDS=1, baseaddr=0, index=0, data=32'h000A000B, waitrequest=0 -> writes 16'h000A @0x0, 16'h000B @0x2 on consecutive cycles; wrdone one cycle later.
REQ-030 SHALL cover: baseaddr=0x1000, index=3, data=32'h01020304 -> writes 16'h0102 @0x100C, 16'h0304 @0x100E.
REQ-031 SHALL cover: waitrequest high 3 cycles on the first halfword -> address, data and write held stable; exactly 2 transfers; wrdone once.
REQ-032 SHALL cover: requests idx 1,2,3 on consecutive cycles without RESULT_WRITER_BUF_EN -> only idx1 accepted until wrdone; with the macro -> idx1 and idx2 accepted, 4 back-to-back transfers, idx3 held off.
REQ-033 SHALL cover: reset asserted after the first halfword transfer -> next cycle avm_m0_write=0, wrdone never pulses, iready=1, and a fresh request writes correctly.
REQ-034 SHALL cover: baseaddr=0xFFFFFFFC, index=1, NDWORDS=1 -> addresses wrap to 0x0 and 0x2.
